// File: rtl/maj_tt_sequencer_pkg.sv
// rtl/maj_tt_sequencer_pkg.sv - shared types, source encoding and config validation helper
//
// Purpose: common definitions for the majority truth-table sequencer.
//   state_t     : sequencer FSM states
//   src_t       : operand select, wide enough for any supported network
//   gate_cfg_t  : one gate slot {sel_a, sel_b, sel_c, inv}
//   sel_ok()    : true when a select names const0, an input, or an available w
package maj_tt_pkg;

  localparam int NUM_VARS_DEF  = 7;
  localparam int MAX_GATES_DEF = 8;

  localparam int SRC_W = 8;
  typedef logic [SRC_W-1:0] src_t;

  // Source encoding: 0 = const0, then x0.., then w0..
  localparam int SRC_CONST0 = 0;
  localparam int SRC_X_BASE = 1;
  localparam int SRC_W_BASE = SRC_X_BASE + NUM_VARS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    src_t       sel_a;
    src_t       sel_b;
    src_t       sel_c;
    logic [2:0] inv;   // bit0 inverts a
  } gate_cfg_t;

  // w_avail = number of w signals the consumer may legally read (w0..w(w_avail-1)).
  // Bounding by w_avail also rejects anything past the end of the encoding.
  function automatic logic sel_ok(input src_t sel, input int num_vars, input int w_avail);
    return int'(sel) < (SRC_X_BASE + num_vars + w_avail);
  endfunction

endpackage

// File: rtl/maj_tt_sequencer_if.sv
// rtl/maj_tt_sequencer_if.sv - configuration/run/result bundle of the majority sequencer
//
// Purpose: groups every non-clock signal of maj_tt_sequencer.
//   master : drives cfg_we, cfg_gate, cfg_sel_a/b/c, cfg_inv, num_gates,
//            out_sel, out_inv, start; receives busy, done, err, tt
//   slave  : the sequencer side (directions mirrored)
interface maj_tt_sequencer_if #(
  parameter int NUM_VARS  = 7,
  parameter int MAX_GATES = 8
);
  localparam int TT_W   = 2 ** NUM_VARS;
  localparam int SEL_W  = $clog2(1 + NUM_VARS + MAX_GATES);
  localparam int GATE_W = $clog2(MAX_GATES);
  localparam int NG_W   = $clog2(MAX_GATES + 1);

  logic              cfg_we;
  logic [GATE_W-1:0] cfg_gate;
  logic [SEL_W-1:0]  cfg_sel_a;
  logic [SEL_W-1:0]  cfg_sel_b;
  logic [SEL_W-1:0]  cfg_sel_c;
  logic [2:0]        cfg_inv;
  logic [NG_W-1:0]   num_gates;
  logic [SEL_W-1:0]  out_sel;
  logic              out_inv;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [TT_W-1:0]   tt;

  modport master (
    output cfg_we, cfg_gate, cfg_sel_a, cfg_sel_b, cfg_sel_c, cfg_inv,
    output num_gates, out_sel, out_inv, start,
    input  busy, done, err, tt
  );

  modport slave (
    input  cfg_we, cfg_gate, cfg_sel_a, cfg_sel_b, cfg_sel_c, cfg_inv,
    input  num_gates, out_sel, out_inv, start,
    output busy, done, err, tt
  );
endinterface

// File: rtl/maj_tt_sequencer_maj3_inv.sv
// rtl/maj_tt_sequencer_maj3_inv.sv - three-input majority with per-input inversion
//
// Purpose: the single shared gate evaluator.
//   a, b, c : operands
//   inv     : per-operand inversion, bit0 = a
//   y       : MAJ(a^inv[0], b^inv[1], c^inv[2])
module maj3_inv (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] inv,
  output logic       y
);
  logic ai, bi, ci;

  assign ai = a ^ inv[0];
  assign bi = b ^ inv[1];
  assign ci = c ^ inv[2];
  assign y  = (ai & bi) | (ai & ci) | (bi & ci);
endmodule

// File: rtl/maj_tt_sequencer.sv
// rtl/maj_tt_sequencer.sv - time-multiplexed majority-network truth-table generator
//
// Purpose: evaluates a programmed list of MAJ3 gates for every input pattern
// and assembles the selected output into a truth table.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of maj_tt_sequencer_if (gate-slot writes, run
//              parameters, start; busy/done/err status and tt result)
module maj_tt_sequencer
  import maj_tt_pkg::*;
#(
  parameter int NUM_VARS  = NUM_VARS_DEF,
  parameter int MAX_GATES = MAX_GATES_DEF
) (
  input logic               clk,
  input logic               rst,
  maj_tt_sequencer_if.slave bus
);
  localparam int TT_W   = 2 ** NUM_VARS;
  localparam int GATE_W = $clog2(MAX_GATES);
  localparam int NG_W   = $clog2(MAX_GATES + 1);
  localparam int W_BASE = SRC_X_BASE + NUM_VARS;

  state_t              state_q, state_d;
  gate_cfg_t           slots [MAX_GATES];
  logic [NUM_VARS-1:0] p_q;
  logic [GATE_W-1:0]   g_q;
  logic [NG_W-1:0]     ng_q;
  src_t                osel_q;
  logic                oinv_q;
  logic [MAX_GATES-1:0] w_q;
  logic [TT_W-1:0]     tt_q;
  logic                err_q, done_q;

  logic      idle_or_done, start_ok, cfg_write, cfg_legal, last_gate, last_pat;
  gate_cfg_t cur;
  logic      op_a, op_b, op_c, maj_y, out_bit;

  // Value of a source at pattern p, given the gate results computed so far.
  function automatic logic src_bit(input src_t sel, input logic [NUM_VARS-1:0] p,
                                   input logic [MAX_GATES-1:0] w);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_VARS; i++)
      if (int'(sel) == SRC_X_BASE + i) v = p[i];
    for (int j = 0; j < MAX_GATES; j++)
      if (int'(sel) == W_BASE + j) v = w[j];
    return v;
  endfunction

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok     = bus.start && idle_or_done;
  assign cfg_write    = bus.cfg_we && idle_or_done;
  assign last_gate    = (int'(g_q) + 1) == int'(ng_q);
  assign last_pat     = &p_q;

  // Checks the stored slots (pre-write values when cfg_we coincides with start).
  always_comb begin
    cfg_legal = 1'b1;
    if (bus.num_gates == '0 || int'(bus.num_gates) > MAX_GATES)
      cfg_legal = 1'b0;
    for (int g = 0; g < MAX_GATES; g++) begin
      if (g < int'(bus.num_gates)) begin
        if (!sel_ok(slots[g].sel_a, NUM_VARS, g) ||
            !sel_ok(slots[g].sel_b, NUM_VARS, g) ||
            !sel_ok(slots[g].sel_c, NUM_VARS, g))
          cfg_legal = 1'b0;
      end
    end
    if (!sel_ok(src_t'(bus.out_sel), NUM_VARS, int'(bus.num_gates)))
      cfg_legal = 1'b0;
  end

  // Shared evaluator fed by the slot of the gate currently being computed.
  assign cur  = slots[g_q];
  assign op_a = src_bit(cur.sel_a, p_q, w_q);
  assign op_b = src_bit(cur.sel_b, p_q, w_q);
  assign op_c = src_bit(cur.sel_c, p_q, w_q);

  maj3_inv u_maj3 (
    .a   (op_a),
    .b   (op_b),
    .c   (op_c),
    .inv (cur.inv),
    .y   (maj_y)
  );

  assign out_bit = src_bit(osel_q, p_q, w_q) ^ oinv_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = cfg_legal ? ST_EVAL : ST_DONE;
      ST_EVAL:          if (last_gate) state_d = ST_STORE;
      ST_STORE:         state_d = last_pat ? ST_DONE : ST_EVAL;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (state_q == ST_EVAL) || (state_q == ST_STORE);
    bus.done = done_q;
    bus.err  = err_q;
    bus.tt   = tt_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_GATES; i++) slots[i] <= '0;  // all-zero = const0 operands, no inversion
      p_q    <= '0;
      g_q    <= '0;
      ng_q   <= '0;
      osel_q <= '0;
      oinv_q <= 1'b0;
      w_q    <= '0;
      tt_q   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // Pulse on entry to DONE; a rejected start issued from DONE re-enters it.
      done_q <= (state_d == ST_DONE) && ((state_q != ST_DONE) || start_ok);

      if (cfg_write && int'(bus.cfg_gate) < MAX_GATES)
        slots[bus.cfg_gate] <= '{sel_a: src_t'(bus.cfg_sel_a),
                                 sel_b: src_t'(bus.cfg_sel_b),
                                 sel_c: src_t'(bus.cfg_sel_c),
                                 inv:   bus.cfg_inv};

      if (start_ok) begin
        tt_q   <= '0;
        err_q  <= !cfg_legal;
        p_q    <= '0;
        g_q    <= '0;
        ng_q   <= bus.num_gates;
        osel_q <= src_t'(bus.out_sel);
        oinv_q <= bus.out_inv;
      end

      case (state_q)
        ST_EVAL: begin
          w_q[g_q] <= maj_y;
          g_q      <= last_gate ? '0 : g_q + 1'b1;
        end
        ST_STORE: begin
          tt_q[p_q] <= out_bit;
          p_q       <= p_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
